// File: rtl/alu_pkg.sv
// Shared op and FSM state encodings for the bit-serial ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_ADD = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_slice.sv
// One-bit AND/ADD/OR/XOR slice; carry out is only meaningful for ADD.
module alu_slice
  import alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic s1,
  input  logic s0,
  output logic y,
  output logic cout
);

  alu_op_e op;

  always_comb begin
    op   = alu_op_e'({s1, s0});
    y    = 1'b0;
    cout = 1'b0;
    unique case (op)
      OP_AND: y = a & b;
      OP_ADD: begin
        y    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: operands consumed LSB first through one alu_slice, result shifted in at MSB.
module serial_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             cin,
  input  logic             s1,
  input  logic             s0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  alu_state_e       state_q;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, last_q;
  logic             busy_q, done_q, cout_q, ovf_q;
  logic             slice_y, slice_cout;

  alu_slice u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s1   (op_q[1]),
    .s0   (op_q[0]),
    .y    (slice_y),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q  <= StIdle;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            op_q    <= alu_op_e'({s1, s0});
            a_q     <= inA;
            b_q     <= inB;
            carry_q <= (alu_op_e'({s1, s0}) == OP_ADD) ? cin : 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          // One settle cycle after the MSB so done lands WIDTH+1 edges after accept.
          if (last_q) begin
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            a_q      <= a_q >> 1;
            b_q      <= b_q >> 1;
            carry_q  <= slice_cout;
            result_q <= {slice_y, result_q[WIDTH-1:1]};
            if (cnt_q == LastCnt) begin
              cnt_q  <= '0;
              last_q <= 1'b1;
              cout_q <= slice_cout;
              ovf_q  <= carry_q ^ slice_cout;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = (result_q == '0);

endmodule
